// File: rtl/hyperbus_read_rx.sv
// rtl/hyperbus_read_rx.sv - HyperBus read receive path: halfword packing, word FIFO, burst control
module hyperbus_read_rx #(
  parameter int LEN_W       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] burst_len_i,
  input  logic             rx_valid_i,
  input  logic [15:0]      rx_data_i,
  output logic [31:0]      data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             overflow_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC);

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   wcnt_q, wcnt_d;
  logic               phase_q, phase_d;
  logic [15:0]        lo_q, lo_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               tmo_q, tmo_d;

  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               push, pop, fifo_wr, full;
  logic [31:0]        push_word;

  assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign valid_o   = (cnt_q != '0);
  assign pop       = valid_o & ready_i;
  assign push_word = {rx_data_i, lo_q};
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign fifo_wr   = push & (~full | pop);
  assign data_o    = valid_o ? mem_q[rd_ptr_q] : 32'h0;

  assign busy_o     = (state_q == S_RECV);
  assign done_o     = done_q;
  assign timeout_o  = tmo_q;
  assign overflow_o = ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      wcnt_q   <= '0;
      phase_q  <= 1'b0;
      lo_q     <= '0;
      to_q     <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wcnt_q   <= wcnt_d;
      phase_q  <= phase_d;
      lo_q     <= lo_d;
      to_q     <= to_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q    <= cnt_q + CNT_W'(fifo_wr) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= push_word;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    phase_d = phase_q;
    lo_d    = lo_q;
    to_d    = to_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    push    = 1'b0;

    case (state_q)
      S_IDLE: begin
        phase_d = 1'b0;
        to_d    = '0;
        if (start_i) begin
          ovf_d  = 1'b0;
          len_d  = burst_len_i;
          wcnt_d = '0;
          if (burst_len_i == '0) done_d  = 1'b1;
          else                   state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (rx_valid_i) begin
          to_d = '0;
          if (!phase_q) begin
            lo_d    = rx_data_i;
            phase_d = 1'b1;
          end else begin
            push    = 1'b1;
            phase_d = 1'b0;
            wcnt_d  = wcnt_q + LEN_W'(1);
            if (wcnt_q + LEN_W'(1) == len_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
          // Stalled RWDS: abandon the burst and drop any unpaired halfword.
          state_d = S_IDLE;
          done_d  = 1'b1;
          tmo_d   = 1'b1;
          phase_d = 1'b0;
          to_d    = '0;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push && full && !pop) ovf_d = 1'b1;
  end

endmodule

// File: tb/tb_hyperbus_read_rx.sv
// tb/tb_hyperbus_read_rx.sv - scoreboard bench for hyperbus_read_rx
module tb_hyperbus_read_rx;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [7:0]  burst_len_i;
  logic        rx_valid_i;
  logic [15:0] rx_data_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;
  logic        done_o;
  logic        timeout_o;
  logic        overflow_o;

  hyperbus_read_rx #(.LEN_W(8), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .burst_len_i(burst_len_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  int          npop   = 0;
  logic [31:0] sb [$];
  logic        bphase;
  logic [15:0] blo;
  logic        exp_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && valid_o && ready_i) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("data", data_o, sb.pop_front());
      npop++;
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_burst(input logic [7:0] len);
    start_i = 1'b1;
    burst_len_i = len;
    tick();
    start_i = 1'b0;
    bphase = 1'b0;
    exp_ovf = 1'b0;
  endtask

  // Model of the receive side: a pair completes on the 2nd halfword and is
  // dropped only if the FIFO is full and the head is not leaving this cycle.
  task automatic drive_hw(input logic [15:0] d);
    logic pop_now;
    rx_valid_i = 1'b1;
    rx_data_i  = d;
    if (!bphase) begin
      blo = d;
      bphase = 1'b1;
    end else begin
      pop_now = ready_i && (sb.size() != 0);
      if (sb.size() == DEPTH && !pop_now) exp_ovf = 1'b1;
      else sb.push_back({d, blo});
      bphase = 1'b0;
    end
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag, input int exp_n);
    int n0;
    n0 = npop;
    ready_i = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    tick();
    check({tag, "_drained"}, 32'(npop - n0), 32'(exp_n));
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({tag, "_valid_low"}, 32'(valid_o), 32'd0);
    ready_i = 1'b0;
  endtask

  initial begin
    int k;
    rst_i = 1'b1; start_i = 1'b0; burst_len_i = '0;
    rx_valid_i = 1'b0; rx_data_i = '0; ready_i = 1'b0;
    bphase = 1'b0; blo = '0; exp_ovf = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    check("rst_valid", 32'(valid_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_timeout", 32'(timeout_o), 0);
    check("rst_overflow", 32'(overflow_o), 0);
    check("rst_data", data_o, 0);

    // Basic two-word burst, consumer always ready
    ready_i = 1'b1;
    start_burst(8'd2);
    check("t1_busy", 32'(busy_o), 1);
    drive_hw(16'h1111);
    drive_hw(16'h2222);
    check("t1_done_early", 32'(done_o), 0);
    check("t1_valid_latency", 32'(valid_o), 1);
    drive_hw(16'h3333);
    drive_hw(16'h4444);
    check("t1_done", 32'(done_o), 1);
    check("t1_busy_after", 32'(busy_o), 0);
    check("t1_valid", 32'(valid_o), 1);
    tick();
    check("t1_done_pulse", 32'(done_o), 0);
    drain("t1", 0);

    // Zero-length burst
    start_burst(8'd0);
    check("t2_done", 32'(done_o), 1);
    check("t2_valid", 32'(valid_o), 0);
    check("t2_busy", 32'(busy_o), 0);
    tick();
    check("t2_done_pulse", 32'(done_o), 0);

    // Overflow with consumer stalled
    ready_i = 1'b0;
    start_burst(8'd6);
    for (int i = 0; i < 12; i++) drive_hw(16'hA000 + 16'(i));
    check("t3_done", 32'(done_o), 1);
    check("t3_overflow", 32'(overflow_o), 32'(exp_ovf));
    tick();
    check("t3_overflow_sticky", 32'(overflow_o), 1);
    drain("t3", 4);

    // RWDS timeout with a dangling halfword
    start_burst(8'd3);
    check("t4_ovf_cleared", 32'(overflow_o), 0);
    drive_hw(16'hB001);
    drive_hw(16'hB002);
    drive_hw(16'hB003);
    k = 0;
    while (!timeout_o && k < 200) begin
      check("t4_done_before_timeout", 32'(done_o), 0);
      tick();
      k++;
    end
    check("t4_idle_cycles", 32'(k), 32'd64);
    check("t4_done", 32'(done_o), 1);
    check("t4_busy", 32'(busy_o), 0);
    bphase = 1'b0;
    tick();
    check("t4_timeout_pulse", 32'(timeout_o), 0);
    drain("t4", 1);

    // Reset in the middle of a burst with two words buffered
    start_burst(8'd4);
    for (int i = 0; i < 5; i++) drive_hw(16'hC000 + 16'(i));
    check("t5_buffered", 32'(valid_o), 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    sb.delete();
    bphase = 1'b0;
    check("t5_valid", 32'(valid_o), 0);
    check("t5_busy", 32'(busy_o), 0);
    check("t5_overflow", 32'(overflow_o), 0);
    check("t5_data", data_o, 0);
    ready_i = 1'b1;
    start_burst(8'd1);
    drive_hw(16'h5678);
    drive_hw(16'h1234);
    check("t5_done", 32'(done_o), 1);
    drain("t5", 1);

    // Full FIFO, final pair lands with a simultaneous pop; start in RECV ignored
    ready_i = 1'b0;
    start_burst(8'd5);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        start_i = 1'b1;
        burst_len_i = 8'd1;
      end
      drive_hw(16'hD000 + 16'(i));
      start_i = 1'b0;
    end
    check("t6_busy_after_ignored_start", 32'(busy_o), 1);
    drive_hw(16'hD008);
    ready_i = 1'b1;
    drive_hw(16'hD009);
    ready_i = 1'b0;
    check("t6_done", 32'(done_o), 1);
    check("t6_no_overflow", 32'(overflow_o), 0);
    check("t6_model_ovf", 32'(exp_ovf), 0);
    drain("t6", 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
